// File: rtl/ysyx_lsu.sv
// Load/store unit: one outstanding EXU request, driven to the bus arbiter through an IDLE/LOAD/STORE/RESP FSM.
// Optional macro YSYX_LSU_ALIGN_CHECK_EN: misaligned half/word accesses fault without touching the bus.
module ysyx_lsu #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready_o,
   input  logic              in_wen,
   input  logic [2:0]        in_funct3,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_wdata,
   output logic              out_valid_o,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_rdata_o,
   output logic              out_fault_o,
   output logic [ADDR_W-1:0] lsu_addr_o,
   output logic              lsu_arvalid_o,
   output logic [7:0]        lsu_rstrb_o,
   input  logic [DATA_W-1:0] lsu_rdata,
   input  logic              lsu_rvalid,
   output logic              lsu_wvalid_o,
   output logic [DATA_W-1:0] lsu_wdata_o,
   output logic [7:0]        lsu_wstrb_o,
   input  logic              lsu_wready
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] STORE = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0]        state;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [2:0]        funct3_q;
   logic [7:0]        strb;
   logic [DATA_W-1:0] load_ext;
   logic              misalign;

   // Reserved width codes (011/110/111) fall into the word strobe.
   always_comb begin
      strb = 8'h0f;
      case (funct3_q[1:0])
         2'b00:   strb = 8'h01;
         2'b01:   strb = 8'h03;
         default: strb = 8'h0f;
      endcase
   end

   // Bus data arrives already right-aligned, so only extension is needed here.
   always_comb begin
      load_ext = lsu_rdata;
      case (funct3_q)
         3'b000:  load_ext = {{(DATA_W-8){lsu_rdata[7]}}, lsu_rdata[7:0]};
         3'b100:  load_ext = {{(DATA_W-8){1'b0}}, lsu_rdata[7:0]};
         3'b001:  load_ext = {{(DATA_W-16){lsu_rdata[15]}}, lsu_rdata[15:0]};
         3'b101:  load_ext = {{(DATA_W-16){1'b0}}, lsu_rdata[15:0]};
         default: load_ext = lsu_rdata;
      endcase
   end

`ifdef YSYX_LSU_ALIGN_CHECK_EN
   logic fault_q;
   assign misalign = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                     (in_funct3[1] && (in_addr[1:0] != 2'b00));
   assign out_fault_o = fault_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         fault_q <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         fault_q <= misalign;
      end
   end
`else
   assign misalign    = 1'b0;
   assign out_fault_o = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         funct3_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  addr_q   <= in_addr;
                  wdata_q  <= in_wdata;
                  funct3_q <= in_funct3;
                  rdata_q  <= '0;
                  if (misalign)
                     state <= RESP;
                  else
                     state <= in_wen ? STORE : LOAD;
               end
            end
            LOAD: begin
               if (lsu_rvalid) begin
                  rdata_q <= load_ext;
                  state   <= RESP;
               end
            end
            STORE: begin
               if (lsu_wready) begin
                  rdata_q <= '0;
                  state   <= RESP;
               end
            end
            default: begin
               if (out_ready)
                  state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready_o    = (state == IDLE);
   assign out_valid_o   = (state == RESP);
   assign out_rdata_o   = rdata_q;
   assign lsu_addr_o    = addr_q;
   assign lsu_wdata_o   = wdata_q;
   assign lsu_arvalid_o = (state == LOAD);
   assign lsu_wvalid_o  = (state == STORE);
   assign lsu_rstrb_o   = lsu_arvalid_o ? strb : 8'h00;
   assign lsu_wstrb_o   = lsu_wvalid_o  ? strb : 8'h00;

endmodule

// File: tb/tb_ysyx_lsu.sv
// Directed bench for ysyx_lsu: loads, stores, backpressure, reset abort, misaligned handling.
module tb_ysyx_lsu;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready_o;
   logic        in_wen;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic        out_valid_o;
   logic        out_ready;
   logic [31:0] out_rdata_o;
   logic        out_fault_o;
   logic [31:0] lsu_addr_o;
   logic        lsu_arvalid_o;
   logic [7:0]  lsu_rstrb_o;
   logic [31:0] lsu_rdata;
   logic        lsu_rvalid;
   logic        lsu_wvalid_o;
   logic [31:0] lsu_wdata_o;
   logic [7:0]  lsu_wstrb_o;
   logic        lsu_wready;

   int checks = 0;
   int errors = 0;
   int both_cnt = 0;

   ysyx_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready_o(in_ready_o), .in_wen(in_wen),
      .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
      .out_valid_o(out_valid_o), .out_ready(out_ready),
      .out_rdata_o(out_rdata_o), .out_fault_o(out_fault_o),
      .lsu_addr_o(lsu_addr_o), .lsu_arvalid_o(lsu_arvalid_o), .lsu_rstrb_o(lsu_rstrb_o),
      .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
      .lsu_wvalid_o(lsu_wvalid_o), .lsu_wdata_o(lsu_wdata_o), .lsu_wstrb_o(lsu_wstrb_o),
      .lsu_wready(lsu_wready)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (lsu_arvalid_o && lsu_wvalid_o) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                           input int wt, input logic [7:0] es,
                           output int arv, output int bad, output logic ov_early);
      arv = 0; bad = 0; ov_early = 1'b0;
      in_valid = 1'b1; in_wen = 1'b0; in_funct3 = f3; in_addr = a; in_wdata = 32'h5555_5555;
      @(negedge clk);
      check("ld_accept_rdy", {31'd0, in_ready_o}, 32'd1);
      step();
      in_valid = 1'b0;
      for (int i = 0; i <= wt; i++) begin
         if (i == wt) begin
            lsu_rvalid = 1'b1;
            lsu_rdata  = rd;
         end
         @(negedge clk);
         if (i == 0) ov_early = out_valid_o;
         if (lsu_arvalid_o) begin
            arv++;
            if (lsu_rstrb_o !== es || lsu_addr_o !== a || lsu_wstrb_o !== 8'h00) bad++;
         end
         step();
         lsu_rvalid = 1'b0;
         lsu_rdata  = '0;
      end
   endtask

   task automatic run_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                            input int wt, input logic [7:0] es,
                            output int wv, output int bad);
      wv = 0; bad = 0;
      in_valid = 1'b1; in_wen = 1'b1; in_funct3 = f3; in_addr = a; in_wdata = wd;
      @(negedge clk);
      check("st_accept_rdy", {31'd0, in_ready_o}, 32'd1);
      step();
      in_valid = 1'b0;
      for (int i = 0; i <= wt; i++) begin
         if (i == wt) lsu_wready = 1'b1;
         @(negedge clk);
         if (lsu_wvalid_o) begin
            wv++;
            if (lsu_wstrb_o !== es || lsu_wdata_o !== wd || lsu_addr_o !== a ||
                lsu_rstrb_o !== 8'h00) bad++;
         end
         step();
         lsu_wready = 1'b0;
      end
   endtask

   task automatic finish_resp(input int hold, input logic [31:0] er, input logic ef, input string t);
      int held_bad;
      held_bad = 0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!out_valid_o || out_rdata_o !== er || out_fault_o !== ef || in_ready_o) held_bad++;
         step();
      end
      if (hold > 0) check({t, "_hold"}, held_bad, 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      check({t, "_valid"}, {31'd0, out_valid_o}, 32'd1);
      check({t, "_rdata"}, out_rdata_o, er);
      check({t, "_fault"}, {31'd0, out_fault_o}, {31'd0, ef});
      check({t, "_busy"}, {31'd0, in_ready_o}, 32'd0);
      step();
      out_ready = 1'b0;
      @(negedge clk);
      check({t, "_idle"}, {31'd0, in_ready_o}, 32'd1);
      check({t, "_vdrop"}, {31'd0, out_valid_o}, 32'd0);
      step();
   endtask

   initial begin
      int arv, bad;
      logic ov_early;

      rst = 1'b1; in_valid = 1'b0; in_wen = 1'b0; in_funct3 = 3'd0; in_addr = '0; in_wdata = '0;
      out_ready = 1'b0; lsu_rdata = '0; lsu_rvalid = 1'b0; lsu_wready = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
      check("rst_arvalid", {31'd0, lsu_arvalid_o}, 32'd0);
      check("rst_wvalid", {31'd0, lsu_wvalid_o}, 32'd0);
      check("rst_fault", {31'd0, out_fault_o}, 32'd0);
      check("rst_rdata", out_rdata_o, 32'd0);
      check("rst_rstrb", {24'd0, lsu_rstrb_o}, 32'd0);
      check("rst_wstrb", {24'd0, lsu_wstrb_o}, 32'd0);
      step();

      // LB with a two-cycle bus wait: sign-extended 0x80
      run_load(3'b000, 32'h8000_0003, 32'h0000_0080, 2, 8'h01, arv, bad, ov_early);
      check("lb_arv_cycles", arv, 32'd3);
      check("lb_bus_stable", bad, 32'd0);
      check("lb_early_valid", {31'd0, ov_early}, 32'd0);
      finish_resp(0, 32'hFFFF_FF80, 1'b0, "lb");

      // LH zero-wait: result valid the cycle after rvalid
      run_load(3'b001, 32'h8000_0000, 32'h0000_8001, 0, 8'h03, arv, bad, ov_early);
      check("lh_arv_cycles", arv, 32'd1);
      check("lh_bus_stable", bad, 32'd0);
      finish_resp(0, 32'hFFFF_8001, 1'b0, "lh");

      run_load(3'b100, 32'h8000_0001, 32'hFFFF_FFF0, 0, 8'h01, arv, bad, ov_early);
      check("lbu_bus_stable", bad, 32'd0);
      finish_resp(0, 32'h0000_00F0, 1'b0, "lbu");

      run_load(3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 1, 8'h0f, arv, bad, ov_early);
      check("lw_arv_cycles", arv, 32'd2);
      check("lw_bus_stable", bad, 32'd0);
      finish_resp(0, 32'hDEAD_BEEF, 1'b0, "lw");

      // LHU with out_ready held low for four cycles
      run_load(3'b101, 32'h8000_0002, 32'hFFFF_8001, 0, 8'h03, arv, bad, ov_early);
      check("lhu_bus_stable", bad, 32'd0);
      finish_resp(4, 32'h0000_8001, 1'b0, "lhu");

      run_store(3'b001, 32'h8000_0002, 32'h1234_ABCD, 1, 8'h03, arv, bad);
      check("sh_wv_cycles", arv, 32'd2);
      check("sh_bus_stable", bad, 32'd0);
      finish_resp(0, 32'h0000_0000, 1'b0, "sh");

      run_store(3'b011, 32'h8000_0008, 32'hCAFE_F00D, 0, 8'h0f, arv, bad);
      check("s_rsv_wv_cycles", arv, 32'd1);
      check("s_rsv_bus_stable", bad, 32'd0);
      finish_resp(0, 32'h0000_0000, 1'b0, "s_rsv");

      run_store(3'b000, 32'h8000_0001, 32'h0000_00AA, 0, 8'h01, arv, bad);
      check("sb_bus_stable", bad, 32'd0);
      finish_resp(0, 32'h0000_0000, 1'b0, "sb");

      // Misaligned word load
      run_load(3'b010, 32'h8000_0002, 32'h1122_3344, 0, 8'h0f, arv, bad, ov_early);
`ifdef YSYX_LSU_ALIGN_CHECK_EN
      check("mis_arv_cycles", arv, 32'd0);
      check("mis_early_valid", {31'd0, ov_early}, 32'd1);
      finish_resp(0, 32'h0000_0000, 1'b1, "mis");
`else
      check("mis_arv_cycles", arv, 32'd1);
      check("mis_bus_stable", bad, 32'd0);
      check("mis_early_valid", {31'd0, ov_early}, 32'd0);
      finish_resp(0, 32'h1122_3344, 1'b0, "mis");
`endif

      // Reset mid-load abandons the access; a stray rvalid afterwards is ignored
      in_valid = 1'b1; in_wen = 1'b0; in_funct3 = 3'b010; in_addr = 32'h8000_0010;
      @(negedge clk);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("abort_arv_before", {31'd0, lsu_arvalid_o}, 32'd1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("abort_arv_after", {31'd0, lsu_arvalid_o}, 32'd0);
      check("abort_in_ready", {31'd0, in_ready_o}, 32'd1);
      check("abort_rstrb", {24'd0, lsu_rstrb_o}, 32'd0);
      step();
      lsu_rvalid = 1'b1;
      lsu_rdata  = 32'hBAD0_BAD0;
      @(negedge clk);
      check("stray_rv_valid0", {31'd0, out_valid_o}, 32'd0);
      step();
      lsu_rvalid = 1'b0;
      @(negedge clk);
      check("stray_rv_valid1", {31'd0, out_valid_o}, 32'd0);
      check("stray_rv_rdata", out_rdata_o, 32'd0);
      step();

      check("ar_w_exclusive", both_cnt, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ysyx_lsu.md
YSYX_LSU -- requirements
Module: ysyx_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  EXU memory request valid.
REQ-006 SHALL have port in_ready_o  output  1  LSU accepts a request.
REQ-007 SHALL have port in_wen  input  1  1=store, 0=load.
REQ-008 SHALL have port in_funct3  input  3  RV32 width/sign code.
REQ-009 SHALL have port in_addr  input  ADDR_W  effective address.
REQ-010 SHALL have port in_wdata  input  DATA_W  store data (rs2, unshifted).
REQ-011 SHALL have port out_valid_o  output  1  result valid to WBU.
REQ-012 SHALL have port out_ready  input  1  WBU accepts result.
REQ-013 SHALL have port out_rdata_o  output  DATA_W  extended load data; 0 for stores.
REQ-014 SHALL have port out_fault_o  output  1  misaligned access fault.
REQ-015 SHALL have port lsu_addr_o  output  ADDR_W  bus address, wired to arbiter lsu_araddr and lsu_awaddr.
REQ-016 SHALL have port lsu_arvalid_o  output  1  load request to arbiter.
REQ-017 SHALL have port lsu_rstrb_o  output  8  load byte strobe.
REQ-018 SHALL have port lsu_rdata  input  DATA_W  arbiter load data, already right-aligned by addr[1:0].
REQ-019 SHALL have port lsu_rvalid  input  1  load data valid.
REQ-020 SHALL have port lsu_wvalid_o  output  1  store request, also drives arbiter lsu_awvalid.
REQ-021 SHALL have port lsu_wdata_o  output  DATA_W  store data, unshifted.
REQ-022 SHALL have port lsu_wstrb_o  output  8  store byte strobe.
REQ-023 SHALL have port lsu_wready  input  1  store accepted.

Function
REQ-024 SHALL implement FSM IDLE, LOAD, STORE, RESP; in_ready_o=1 only in IDLE.
REQ-025 On in_valid&in_ready_o SHALL latch addr, wdata, funct3, wen; next state LOAD (wen=0) or STORE (wen=1).
REQ-026 Strobe from funct3[1:0]: 00 -> 8'h01, 01 -> 8'h03, others -> 8'h0f; reserved funct3 011/110/111 treated as word.
REQ-027 LOAD: lsu_arvalid_o=1 with stable lsu_addr_o/lsu_rstrb_o until the cycle lsu_rvalid=1; then capture data, go RESP.
REQ-028 Load extension: 000 sign-extend [7:0]; 100 zero-extend [7:0]; 001 sign-extend [15:0]; 101 zero-extend [15:0]; else full word.
REQ-029 STORE: lsu_wvalid_o=1 with stable addr/wdata/wstrb until the cycle lsu_wready=1; then go RESP with out_rdata_o=0.
REQ-030 RESP: out_valid_o=1, out_rdata_o/out_fault_o held stable until out_ready=1; then IDLE.
REQ-031 Minimum latency: accept cycle N, bus request N+1, out_valid_o the cycle after rvalid/wready (3 cycles with zero-wait bus).
REQ-032 lsu_rvalid/lsu_wready outside LOAD/STORE respectively SHALL be ignored.
REQ-033 lsu_arvalid_o and lsu_wvalid_o SHALL never be asserted in the same cycle.
REQ-034 No new request accepted until RESP handshake completes (one outstanding).

Reset
REQ-035 rst SHALL force IDLE from any state, including mid-LOAD/STORE, abandoning the access.
REQ-036 After reset: in_ready_o=1, out_valid_o=0, lsu_arvalid_o=0, lsu_wvalid_o=0, out_fault_o=0, out_rdata_o=0, strobes 0.

Configuration
REQ-037 Macro YSYX_LSU_ALIGN_CHECK_EN defined: halfword with addr[0]!=0 or word with addr[1:0]!=0 SHALL skip bus access, go directly to RESP with out_fault_o=1, out_rdata_o=0.
REQ-038 Macro undefined: out_fault_o tied 0; misaligned accesses issued to bus unchanged.

Verification
REQ-039 Load funct3=000 addr 0x80000003, lsu_rdata=0x00000080 after 2-cycle wait -> out_rdata_o=0xFFFFFF80, lsu_rstrb_o=0x01, arvalid held 3 cycles.
REQ-040 Store funct3=001 addr 0x80000002 wdata 0x1234ABCD, wready 1 cycle later -> lsu_wstrb_o=0x03, lsu_wdata_o=0x1234ABCD, out_rdata_o=0.
REQ-041 Load funct3=101, rdata 0xFFFF8001, out_ready low 4 cycles -> out_rdata_o=0x00008001 held, in_ready_o=0 throughout.
REQ-042 rst asserted during LOAD with arvalid high -> next cycle arvalid=0, in_ready_o=1; later stray rvalid produces no out_valid_o.
REQ-043 With YSYX_LSU_ALIGN_CHECK_EN, load funct3=010 addr 0x80000002 -> no arvalid, out_valid_o 1 cycle after accept, out_fault_o=1; without macro, arvalid issued, fault 0.
